if_stage: RTL and testbench



---
 rtl/if_stage_pkg.sv | 22 ++
 rtl/if_hold_buf.sv | 43 ++++
 rtl/if_stage.sv | 173 +++++++++++++++++
 tb/tb_if_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: data width, NOP
// encoding, default reset PC and the fetch FSM state encoding.
package if_stage_pkg;

    localparam int XLEN = 32;

    // ADDI x0,x0,0 -- what the decoder sees whenever IF/ID holds a bubble
    localparam logic [XLEN-1:0] IF_NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] IF_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_REQ  = 2'd0,
        IF_WAIT = 2'd1,
        IF_HOLD = 2'd2
    } if_state_e;

    // Fetch targets are always word aligned; low two bits are dropped
    function automatic logic [XLEN-1:0] if_align_word(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry {pc, inst} buffer that parks a returned instruction while the
// hazard unit stalls the IF/ID register. Clear wins over load, load over unload.
module if_hold_buf
    import if_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_unload,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_inst,
    output logic            o_full,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_inst
);

    logic            r_full;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;

    // Occupancy flag and stored entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_pc   <= '0;
            r_inst <= IF_NOP_INST;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_pc   <= i_pc;
            r_inst <= i_inst;
        end else if (i_unload) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_pc   = r_pc;
    assign o_inst = r_inst;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, talks to imem over req/gnt/rvalid
// with one request outstanding, and fills the IF/ID register for the decoder.
// Stalls park a returning word in if_hold_buf; EX redirects flush IF/ID and
// kill any fetch still in flight.
// Optional build macro IF_PERF_CNT_EN adds fetch and bubble counters.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = IF_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INST = IF_NOP_INST
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            id_valid_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_inst_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt_o,
    output logic [31:0]     perf_bubble_cnt_o
`endif
);

    if_state_e       r_state;
    if_state_e       w_next_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_kill;
    logic            r_id_valid;
    logic [XLEN-1:0] r_id_pc;
    logic [XLEN-1:0] r_id_inst;

    logic            w_grant;
    logic            w_rsp;
    logic            w_rsp_keep;
    logic            w_buf_load;
    logic            w_buf_unload;
    logic            w_buf_full;
    logic            w_id_load;
    logic [XLEN-1:0] w_buf_pc;
    logic [XLEN-1:0] w_buf_inst;
    logic [XLEN-1:0] w_load_pc;
    logic [XLEN-1:0] w_load_inst;

    assign w_grant      = (r_state == IF_REQ) && imem_gnt_i;
    assign w_rsp        = (r_state == IF_WAIT) && imem_rvalid_i;
    assign w_rsp_keep   = w_rsp && !r_kill && !redirect_i;
    assign w_buf_load   = w_rsp_keep && stall_i;
    assign w_buf_unload = (r_state == IF_HOLD) && w_buf_full && !stall_i && !redirect_i;
    assign w_id_load    = (w_rsp_keep && !stall_i) || w_buf_unload;
    assign w_load_pc    = w_buf_unload ? w_buf_pc   : r_req_pc;
    assign w_load_inst  = w_buf_unload ? w_buf_inst : imem_rdata_i;

    assign imem_addr_o  = r_fetch_pc;
    assign id_valid_o   = r_id_valid;
    assign id_pc_o      = r_id_pc;
    assign id_inst_o    = r_id_inst;

    if_hold_buf u_hold_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_buf_load),
        .i_unload (w_buf_unload),
        .i_clear  (redirect_i),
        .i_pc     (r_req_pc),
        .i_inst   (imem_rdata_i),
        .o_full   (w_buf_full),
        .o_pc     (w_buf_pc),
        .o_inst   (w_buf_inst)
    );

    // Fetch FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IF_REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: a redirect never blocks a grant, and always leaves WAIT-with-data or HOLD for REQ
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IF_REQ: begin
                if (imem_gnt_i) w_next_state = IF_WAIT;
            end
            IF_WAIT: begin
                if (imem_rvalid_i) begin
                    if (redirect_i || r_kill || !stall_i) w_next_state = IF_REQ;
                    else                                  w_next_state = IF_HOLD;
                end
            end
            IF_HOLD: begin
                if (redirect_i || !stall_i) w_next_state = IF_REQ;
            end
            default: w_next_state = IF_REQ;
        endcase
    end

    // Request is only raised from REQ; HOLD deliberately stops fetching
    always_comb begin
        imem_req_o = (r_state == IF_REQ);
    end

    // PC, PC of the outstanding request, and the kill flag for a stale response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_kill     <= 1'b0;
        end else begin
            if (redirect_i)   r_fetch_pc <= if_align_word(redirect_pc_i);
            else if (w_grant) r_fetch_pc <= r_fetch_pc + XLEN'(4);

            if (w_grant) r_req_pc <= r_fetch_pc;

            if (redirect_i && (w_grant || ((r_state == IF_WAIT) && !imem_rvalid_i)))
                r_kill <= 1'b1;
            else if (w_rsp)
                r_kill <= 1'b0;
        end
    end

    // IF/ID register: redirect flushes, stall holds, otherwise load or insert a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= '0;
            r_id_inst  <= NOP_INST;
        end else if (redirect_i) begin
            r_id_valid <= 1'b0;
            r_id_inst  <= NOP_INST;
        end else if (!stall_i) begin
            if (w_id_load) begin
                r_id_valid <= 1'b1;
                r_id_pc    <= w_load_pc;
                r_id_inst  <= w_load_inst;
            end else begin
                r_id_valid <= 1'b0;
                r_id_inst  <= NOP_INST;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_bubble_cnt;

    // Free-running wrapping counters for delivered instructions and bubble cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch_cnt  <= '0;
            r_perf_bubble_cnt <= '0;
        end else begin
            if (w_id_load)   r_perf_fetch_cnt  <= r_perf_fetch_cnt + 32'd1;
            if (!r_id_valid) r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
        end
    end

    assign perf_fetch_cnt_o  = r_perf_fetch_cnt;
    assign perf_bubble_cnt_o = r_perf_bubble_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: an imem responder plus a transaction-level model of
// the fetch stream (next fetch address, stale responses, one parked word and
// the expected IF/ID contents), compared every cycle and at directed points.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_bubble_cnt_o;
`endif

    if_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .id_valid_o    (id_valid_o),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o  (perf_fetch_cnt_o),
        .perf_bubble_cnt_o (perf_bubble_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;

    // memory behaviour knobs
    int gntPct = 100;
    int latMin = 1;
    int latMax = 1;

    // memory / model state
    bit          memPending = 1'b0;
    bit          memStale   = 1'b0;
    logic [31:0] memAddr    = '0;
    int          delayLeft  = 0;
    bit          bufValid   = 1'b0;
    logic [31:0] bufPc      = '0;
    logic [31:0] nextFetch  = '0;
    logic        expValid   = 1'b0;
    logic [31:0] expPc      = '0;
    logic [31:0] expInst    = NOP;
    int unsigned expFetches = 0;
    int unsigned expBubbles = 0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge: update the model from the inputs seen at the edge,
    // compare the DUT, then drive the memory side for the next cycle.
    task automatic applyStimulus();
        logic        preReq, preGnt, preRv, preStall, preRedir, loadNow;
        logic [31:0] preTarget, loadPc;
        preReq    = imem_req_o;
        preGnt    = imem_gnt_i;
        preRv     = imem_rvalid_i;
        preStall  = stall_i;
        preRedir  = redirect_i;
        preTarget = redirect_pc_i;
        loadNow   = 1'b0;
        loadPc    = '0;
        @(posedge clk);
        #1;
        if (!expValid) expBubbles++;
        if (preRedir) begin
            bufValid = 1'b0;
            if (memPending) memStale = 1'b1;
        end
        if (preRv) begin
            memPending = 1'b0;
            if (!memStale && !preRedir) begin
                if (preStall) begin
                    bufValid = 1'b1;
                    bufPc    = memAddr;
                end else begin
                    loadNow = 1'b1;
                    loadPc  = memAddr;
                end
            end
            memStale = 1'b0;
        end else if (bufValid && !preStall && !preRedir) begin
            loadNow  = 1'b1;
            loadPc   = bufPc;
            bufValid = 1'b0;
        end
        if (preRedir) begin
            expValid = 1'b0;
            expInst  = NOP;
        end else if (!preStall) begin
            if (loadNow) begin
                expValid = 1'b1;
                expPc    = loadPc;
                expInst  = memWord(loadPc);
                expFetches++;
            end else begin
                expValid = 1'b0;
                expInst  = NOP;
            end
        end
        if (preReq && preGnt) begin
            memPending = 1'b1;
            memAddr    = nextFetch;
            memStale   = preRedir;
            delayLeft  = $urandom_range(latMax, latMin) - 1;
        end
        if (preRedir)                nextFetch = preTarget & ~32'h3;
        else if (preReq && preGnt)   nextFetch = nextFetch + 32'd4;

        checkOutput("id_valid", {31'b0, id_valid_o}, {31'b0, expValid});
        checkOutput("id_pc", id_pc_o, expPc);
        checkOutput("id_inst", id_inst_o, expInst);
        checkOutput("imem_req", {31'b0, imem_req_o}, {31'b0, !memPending && !bufValid});
        checkOutput("imem_addr", imem_addr_o, nextFetch);

        imem_gnt_i = imem_req_o && ($urandom_range(99, 0) < gntPct);
        if (memPending && delayLeft == 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = memWord(memAddr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom();
            if (memPending) delayLeft--;
        end
    endtask

    task automatic waitValid(input string tag, input int budget);
        for (int i = 0; i < budget && !id_valid_o; i++) applyStimulus();
        checkOutput(tag, {31'b0, id_valid_o}, 32'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req", {31'b0, imem_req_o}, 32'd1);
        checkOutput("rst_addr", imem_addr_o, 32'h0);
        checkOutput("rst_valid", {31'b0, id_valid_o}, 32'd0);
        checkOutput("rst_pc", id_pc_o, 32'h0);
        checkOutput("rst_inst", id_inst_o, NOP);
        rst_n      = 1'b1;
        imem_gnt_i = 1'b1;

        // back-to-back fetch with single-cycle memory
        applyStimulus();
        applyStimulus();
        checkOutput("tp1_valid0", {31'b0, id_valid_o}, 32'd1);
        checkOutput("tp1_pc0", id_pc_o, 32'h0);
        checkOutput("tp1_inst0", id_inst_o, memWord(32'h0));
        applyStimulus();
        checkOutput("tp1_gap", {31'b0, id_valid_o}, 32'd0);
        applyStimulus();
        checkOutput("tp1_pc4", id_pc_o, 32'h4);
        checkOutput("tp1_inst4", id_inst_o, memWord(32'h4));

        // stall while word at 0x8 returns
        stall_i = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("tp2_noreq", {31'b0, imem_req_o}, 32'd0);
        checkOutput("tp2_holdpc", id_pc_o, 32'h4);
        applyStimulus();
        checkOutput("tp2_noreq2", {31'b0, imem_req_o}, 32'd0);
        stall_i = 1'b0;
        applyStimulus();
        checkOutput("tp2_pc8", id_pc_o, 32'h8);
        checkOutput("tp2_inst8", id_inst_o, memWord(32'h8));
        checkOutput("tp2_addrC", imem_addr_o, 32'hC);

        // redirect while waiting on a slow fetch of 0x10
        applyStimulus();
        applyStimulus();
        latMin = 3;
        latMax = 3;
        applyStimulus();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        applyStimulus();
        redirect_i = 1'b0;
        checkOutput("tp3_flush", id_inst_o, NOP);
        latMin = 1;
        latMax = 1;
        waitValid("tp3_timeout", 20);
        checkOutput("tp3_pc100", id_pc_o, 32'h100);

        // redirect in REQ without grant, then redirect coinciding with grant
        imem_gnt_i    = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h20;
        applyStimulus();
        checkOutput("tp4_addr20", imem_addr_o, 32'h20);
        redirect_pc_i = 32'h202;
        applyStimulus();
        redirect_i = 1'b0;
        checkOutput("tp4_addr200", imem_addr_o, 32'h200);
        waitValid("tp4_timeout", 20);
        checkOutput("tp4_pc200", id_pc_o, 32'h200);

        // redirect together with stall while a word is parked
        stall_i = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("tp5_hold", {31'b0, imem_req_o}, 32'd0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h300;
        applyStimulus();
        redirect_i = 1'b0;
        stall_i    = 1'b0;
        checkOutput("tp5_addr300", imem_addr_o, 32'h300);
        waitValid("tp5_timeout", 20);
        checkOutput("tp5_pc300", id_pc_o, 32'h300);

        // randomized traffic
        gntPct = 60;
        latMax = 3;
        for (int i = 0; i < 600; i++) begin
            stall_i       = ($urandom_range(99, 0) < 25);
            redirect_i    = ($urandom_range(99, 0) < 6);
            redirect_pc_i = $urandom();
            applyStimulus();
        end
        stall_i    = 1'b0;
        redirect_i = 1'b0;

        // PC wrap at the top of the address space
        gntPct        = 100;
        latMax        = 1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        applyStimulus();
        redirect_i = 1'b0;
        waitValid("wrap_timeout", 30);
        checkOutput("wrap_pc", id_pc_o, 32'hFFFF_FFFC);
        checkOutput("wrap_addr", imem_addr_o, 32'h0);
        applyStimulus();
        applyStimulus();

`ifdef IF_PERF_CNT_EN
        checkOutput("perf_fetch", perf_fetch_cnt_o, expFetches);
        checkOutput("perf_bubble", perf_bubble_cnt_o, expBubbles);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
